cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 90 +++++++++
 tb/tb_cpu_core.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Minimal 4-bit accumulator CPU: one instruction per clock, combinational ROM fetch.
// Optional JMP/JNC decode is compiled in when CPU_CORE_JUMP_EN is defined.
module cpu_core #(
  parameter logic [3:0] RESET_PC = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [3:0] pc,
  input  logic [3:0] opcode,
  input  logic [3:0] imdata,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       out_valid,
  output logic       carry
);

  typedef enum logic [3:0] {
    OP_ADD_A = 4'b0000,
    OP_ADD_B = 4'b0001,
    OP_MOV_A = 4'b0010,
    OP_MOV_B = 4'b0011,
    OP_A_B   = 4'b0100,
    OP_B_A   = 4'b0101,
    OP_IN_A  = 4'b0110,
    OP_IN_B  = 4'b0111,
    OP_OUT_A = 4'b1000,
    OP_OUT_B = 4'b1001,
    OP_OUT_I = 4'b1011,
    OP_JNC   = 4'b1110,
    OP_JMP   = 4'b1111
  } op_e;

  logic [3:0] a, b;
  logic [3:0] nxt_pc, nxt_a, nxt_b, nxt_out;
  logic       nxt_carry, nxt_valid;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    nxt_pc    = pc + 4'd1;
    nxt_a     = a;
    nxt_b     = b;
    nxt_out   = out_port;
    nxt_carry = 1'b0;
    nxt_valid = 1'b0;
    case (opcode)
      OP_ADD_A: {nxt_carry, nxt_a} = {1'b0, a} + {1'b0, imdata};
      OP_ADD_B: {nxt_carry, nxt_b} = {1'b0, b} + {1'b0, imdata};
      OP_MOV_A: nxt_a = imdata;
      OP_MOV_B: nxt_b = imdata;
      OP_A_B:   nxt_a = b;
      OP_B_A:   nxt_b = a;
      OP_IN_A:  nxt_a = in_port;
      OP_IN_B:  nxt_b = in_port;
      OP_OUT_A: begin nxt_out = a;      nxt_valid = 1'b1; end
      OP_OUT_B: begin nxt_out = b;      nxt_valid = 1'b1; end
      OP_OUT_I: begin nxt_out = imdata; nxt_valid = 1'b1; end
`ifdef CPU_CORE_JUMP_EN
      OP_JMP:   nxt_pc = imdata;
      // JNC looks at the carry registered before this edge.
      OP_JNC:   if (!carry) nxt_pc = imdata;
`endif
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      a         <= 4'd0;
      b         <= 4'd0;
      carry     <= 1'b0;
      out_port  <= 4'd0;
      out_valid <= 1'b0;
    end else if (run) begin
      pc        <= nxt_pc;
      a         <= nxt_a;
      b         <= nxt_b;
      carry     <= nxt_carry;
      out_port  <= nxt_out;
      out_valid <= nxt_valid;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus randomized ROM/inputs
// compared every cycle against an arithmetic instruction-level model.
module tb_cpu_core;

  localparam logic [3:0] RPC = 4'h0;
`ifdef CPU_CORE_JUMP_EN
  localparam bit JUMP = 1'b1;
`else
  localparam bit JUMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] in_port = 4'd0;
  logic [3:0] pc, opcode, imdata, out_port;
  logic       out_valid, carry;

  logic [7:0] rom [16];
  assign opcode = rom[pc][7:4];
  assign imdata = rom[pc][3:0];

  cpu_core #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc), .opcode(opcode), .imdata(imdata),
    .in_port(in_port), .out_port(out_port), .out_valid(out_valid), .carry(carry)
  );

  always #5 clk = ~clk;

  int m_pc, m_a, m_b, m_c, m_out, m_ov;
  int vectors = 0;
  int fails   = 0;
  int outs[$];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: next architectural state from the current one.
  function void model_edge();
    int op, im, s, npc, nc;
    if (rst) begin
      m_pc = RPC; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_ov = 0;
    end else if (!run) begin
      m_ov = 0;
    end else begin
      op  = int'(rom[m_pc][7:4]);
      im  = int'(rom[m_pc][3:0]);
      npc = (m_pc + 1) % 16;
      nc  = 0;
      m_ov = 0;
      case (op)
        0:  begin s = m_a + im; m_a = s % 16; nc = s / 16; end
        1:  begin s = m_b + im; m_b = s % 16; nc = s / 16; end
        2:  m_a = im;
        3:  m_b = im;
        4:  m_a = m_b;
        5:  m_b = m_a;
        6:  m_a = int'(in_port);
        7:  m_b = int'(in_port);
        8:  begin m_out = m_a; m_ov = 1; end
        9:  begin m_out = m_b; m_ov = 1; end
        11: begin m_out = im;  m_ov = 1; end
        14: if (JUMP && m_c == 0) npc = im;
        15: if (JUMP) npc = im;
        default: ;
      endcase
      m_c  = nc;
      m_pc = npc;
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) outs.push_back(int'(out_port));
    check("pc",        pc,              4'(m_pc));
    check("carry",     {3'b0, carry},   4'(m_c));
    check("out_port",  out_port,        4'(m_out));
    check("out_valid", {3'b0, out_valid}, 4'(m_ov));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{1, 2, 4, 8, 4, 0};
    fill_rom(8'hC0);

    // Reset state, applied while run is low.
    do_reset();
    check("rst_pc", pc, RPC);
    check("rst_out", out_port, 4'h0);
    check("rst_valid", {3'b0, out_valid}, 4'h0);

    // Standard program: out_port sequence 1,2,4,8,4,0.
    rom[0] = 8'h21; rom[1] = 8'h80; rom[2] = 8'h01; rom[3] = 8'h80;
    rom[4] = 8'h34; rom[5] = 8'h90; rom[6] = 8'hB8; rom[7] = 8'h90;
    rom[8] = 8'h20; rom[9] = 8'h80; rom[10] = 8'hFA;
    run = 1'b1;
    do_reset();
    outs.delete();
    repeat (12) step();
    check("std_count", 4'(outs.size()), 4'd6);
    for (int i = 0; i < 6; i++)
      check("std_seq", (i < outs.size()) ? 4'(outs[i]) : 4'hX, 4'(exp_seq[i]));

    // Carry out of ADD, then JNC falls through and clears carry.
    fill_rom(8'hC0);
    rom[0] = 8'h2F; rom[1] = 8'h01; rom[2] = 8'hE5; rom[3] = 8'h80;
    do_reset();
    step();
    step();
    check("add_carry", {3'b0, carry}, 4'h1);
    step();
    check("jnc_fall_pc", pc, 4'h3);
    check("jnc_clr_carry", {3'b0, carry}, 4'h0);
    step();
    check("add_wrap_a", out_port, 4'h0);

    // JNC with carry clear.
    fill_rom(8'hC0);
    rom[0] = 8'hEA;
    do_reset();
    step();
    check("jnc_taken", pc, JUMP ? 4'hA : 4'h1);

    // Freeze with run low, then pc wrap from F to 0.
    fill_rom(8'hC0);
    rom[0] = 8'hB5;
    do_reset();
    step();
    run = 1'b0;
    repeat (3) begin
      step();
      check("frz_pc", pc, 4'h1);
      check("frz_out", out_port, 4'h5);
      check("frz_valid", {3'b0, out_valid}, 4'h0);
    end
    run = 1'b1;
    repeat (14) step();
    check("pc_at_f", pc, 4'hF);
    step();
    check("pc_wrap", pc, 4'h0);

    // IN B / OUT B, then reset on the same edge as OUT A.
    fill_rom(8'hC0);
    rom[0] = 8'h70; rom[1] = 8'h90; rom[2] = 8'h80;
    in_port = 4'h6;
    do_reset();
    step();
    step();
    check("in_out_b", out_port, 4'h6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_out", out_port, 4'h0);
    check("rst_mid_valid", {3'b0, out_valid}, 4'h0);
    check("rst_mid_pc", pc, RPC);

    // Randomized programs, run gating, inputs and occasional reset.
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0)
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      run     = ($urandom_range(9) != 0);
      rst     = ($urandom_range(39) == 0);
      in_port = 4'($urandom);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
